serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (>= 2).
REQ-002 The block SHALL have parameter DIGIT, default 2, bits added per clock; WIDTH % DIGIT == 0 is mandatory and SHALL be elaborated with an error otherwise.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and mode presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  operands, unsigned (or two's complement for ovf).
REQ-008 sub  input  1  0 = a+b, 1 = a-b; sampled with operands.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 res  output  WIDTH+1  res[WIDTH-1:0] sum/difference; res[WIDTH] carry (add) or borrow (sub).
REQ-012 ovf  output  1  signed overflow flag (see Configuration).
REQ-013 busy  output  1  high in RUN.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE); busy = (state == RUN).
REQ-015 IDLE: on in_valid && in_ready, capture a, b (b bitwise inverted if sub), sub; carry register = sub; digit counter = 0; go RUN.
REQ-016 RUN: each cycle add the DIGIT-bit slice at counter position plus carry register, write DIGIT result bits into res shadow, update carry, increment counter.
REQ-017 RUN SHALL last exactly WIDTH/DIGIT cycles, then go DONE; out_valid rises WIDTH/DIGIT+1 cycles after the accept edge.
REQ-018 res[WIDTH] SHALL be final carry for add, inverted final carry for sub (1 = a < b unsigned).
REQ-019 res and ovf SHALL hold stable while out_valid is high and out_ready is low.
REQ-020 DONE with out_ready high SHALL return to IDLE next cycle; in_ready is low in DONE (no same-cycle accept).
REQ-021 in_valid while not in_ready SHALL be ignored; operands do not need to be held after accept.
REQ-022 Inputs a, b, sub changing during RUN SHALL not affect the result.

Reset
REQ-023 RESET_N low SHALL force state IDLE, res = 0, ovf = 0, carry = 0, counter = 0, out_valid = 0, busy = 0, in_ready = 0 while asserted.
REQ-024 Reset mid-RUN or mid-DONE SHALL abort silently; no out_valid pulse after release; in_ready = 1 first cycle after release.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: ovf = carry into MSB XOR carry out of MSB, registered at the RUN->DONE transition, cleared on return to IDLE.
REQ-026 Macro SERIAL_ADDER_OVF_EN undefined: ovf port present and constant 0; no overflow logic synthesised.

Structure
REQ-027 Package serial_adder_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and a counter-width function clog2(WIDTH/DIGIT) with minimum 1.
REQ-028 Sub-module digit_adder SHALL be a combinational DIGIT-bit ripple adder (a, b, cin -> s, cout, c_msb_in), instantiated once.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-029 a=200, b=100, sub=0, out_ready=1 -> busy 4 cycles, out_valid 5 cycles after accept, res=9'h12C.
REQ-030 a=5, b=7, sub=1 -> res[7:0]=8'hFE, res[8]=1; a=7, b=5, sub=1 -> res=9'h002.
REQ-031 With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01, sub=0 -> res[7:0]=8'h80, ovf=1; a=8'h80, b=8'h01, sub=1 -> ovf=1; without macro ovf=0 in both.
REQ-032 out_ready low 10 cycles in DONE -> res/out_valid stable, in_ready low; in_valid pulses during that time ignored; out_ready high -> in_ready next cycle.
REQ-033 RESET_N low on 2nd RUN cycle -> all outputs per REQ-023, no out_valid afterwards, next operation a=1, b=1 gives res=2.
REQ-034 WIDTH=3, DIGIT=1, exhaustive a, b in 0..7, sub=0 -> res = a+b (4 bits) every case, 4-cycle latency.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the digit-serial adder.
//   state_t : FSM encoding (IDLE / RUN / DONE)
//   clog2   : counter width for a given digit count, never less than 1 bit
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-digit configuration still needs a one-bit counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
// Operand/result handshake bundle for serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (res, ovf)
//   busy                : adder is stepping through digits
// Modports: master = producer/consumer side, slave = the adder.
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   res;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, res, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, res, ovf, busy
  );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple-carry adder.
//   a, b     : DIGIT-bit addends
//   cin      : carry in
//   s        : DIGIT-bit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow detection)
// ---------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Ripple chain: c[i] is the carry into bit i.
  always_comb begin : ripple
    logic [DIGIT:0] c;
    c    = '0;
    c[0] = cin;
    s    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout     = c[DIGIT];
    c_msb_in = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Digit-serial adder/subtractor: adds DIGIT bits per clock, WIDTH/DIGIT
// clocks per operation, with valid/ready handshakes on both sides.
//   CLOCK_50 : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : serial_adder_if.slave (operands, result, ovf, busy)
// Optional feature: define SERIAL_ADDER_OVF_EN to compute the signed
// overflow flag; otherwise ovf is tied to 0 and no overflow logic exists.
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  serial_adder_if.slave  bus
);

  localparam int             NDIG = WIDTH / DIGIT;
  localparam int             CW   = clog2(NDIG);
  localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

  if (WIDTH < 2) begin : g_badWidth
    $error("serial_adder: WIDTH must be at least 2");
  end
  if (WIDTH % DIGIT != 0) begin : g_badDigit
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           r_state;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_res;

  logic [DIGIT-1:0] w_aDigit;
  logic [DIGIT-1:0] w_bDigit;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cMsbIn;

  assign w_aDigit = r_a[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_bDigit = r_b[int'(r_cnt) * DIGIT +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_digitAdder (
    .a        (w_aDigit),
    .b        (w_bDigit),
    .cin      (r_carry),
    .s        (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cMsbIn)
  );

  // Control FSM plus datapath registers. Subtraction is a + ~b + 1, so the
  // operand is inverted at capture and the initial carry is the sub bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_res      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a       <= bus.a;
            r_b       <= bus.sub ? ~bus.b : bus.b;
            r_sub     <= bus.sub;
            r_carry   <= bus.sub;
            r_cnt     <= '0;
            r_state   <= RUN;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        RUN: begin
          r_res[int'(r_cnt) * DIGIT +: DIGIT] <= w_sum;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // For subtraction a set carry means "no borrow", hence the flip.
            r_res[WIDTH] <= w_cout ^ r_sub;
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_outValid   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Gating with RESET_N keeps in_ready low during reset yet high in the
  // very first cycle after release.
  assign bus.in_ready  = r_inReady & RESET_N;
  assign bus.out_valid = r_outValid;
  assign bus.busy      = r_busy;
  assign bus.res       = r_res;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow is decided by the top digit only: carry into the MSB
  // differing from carry out of it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && r_cnt == LAST) begin
      r_ovf <= w_cMsbIn ^ w_cout;
    end else if (r_state == DONE && bus.out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.ovf = r_ovf;
`else
  logic w_unused;
  assign w_unused = w_cMsbIn;
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder: an 8-bit/2-bit-digit instance for the
// arithmetic, handshake, hold and reset cases, and a 3-bit/1-bit-digit
// instance swept over all operand pairs. Expected ovf follows
// SERIAL_ADDER_OVF_EN.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic clk;
  logic rstN;
  int   totalChecks = 0;
  int   badChecks   = 0;

`ifdef SERIAL_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(3)) bus3 ();

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .CLOCK_50 (clk),
    .RESET_N  (rstN),
    .bus      (bus8)
  );

  serial_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
    .CLOCK_50 (clk),
    .RESET_N  (rstN),
    .bus      (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-computed vectors: a, b, sub -> res, and ovf when the feature is on.
  logic [7:0] vecA   [7] = '{8'd200, 8'd5,   8'd7,   8'h7F,  8'h80,  8'hFF,  8'h00};
  logic [7:0] vecB   [7] = '{8'd100, 8'd7,   8'd5,   8'h01,  8'h01,  8'hFF,  8'h00};
  logic       vecSub [7] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
  logic [8:0] vecRes [7] = '{9'h12C, 9'h1FE, 9'h002, 9'h080, 9'h07F, 9'h1FE, 9'h000};
  logic       vecOvf [7] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full 8-bit transaction; returns once out_valid is seen at a negedge.
  // latency counts cycles from the accept cycle to the first out_valid cycle.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic opSub,
                               output logic [8:0] gotRes, output logic gotOvf,
                               output int busyCycles, output int latency);
    int   waitCount;
    logic seen;
    waitCount = 0;
    while (bus8.in_ready !== 1'b1 && waitCount < 20) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("in_ready before accept", bus8.in_ready, 1);
    bus8.in_valid = 1'b1;
    bus8.a        = opA;
    bus8.b        = opB;
    bus8.sub      = opSub;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a        = 8'($urandom);
    bus8.b        = 8'($urandom);
    bus8.sub      = 1'($urandom_range(0, 1));
    seen       = 1'b0;
    latency    = 0;
    busyCycles = 0;
    while (!seen && latency < 40) begin
      @(negedge clk);
      latency++;
      if (bus8.busy === 1'b1) busyCycles++;
      if (bus8.out_valid === 1'b1) seen = 1'b1;
    end
    checkOutput("out_valid seen", seen, 1);
    gotRes = bus8.res;
    gotOvf = bus8.ovf;
  endtask

  task automatic applyStimulusNarrow(input logic [2:0] opA, input logic [2:0] opB,
                                     output logic [3:0] gotRes, output int latency);
    int   waitCount;
    logic seen;
    waitCount = 0;
    while (bus3.in_ready !== 1'b1 && waitCount < 20) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("narrow in_ready", bus3.in_ready, 1);
    bus3.in_valid = 1'b1;
    bus3.a        = opA;
    bus3.b        = opB;
    bus3.sub      = 1'b0;
    @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    bus3.a        = 3'($urandom);
    bus3.b        = 3'($urandom);
    seen    = 1'b0;
    latency = 0;
    while (!seen && latency < 40) begin
      @(negedge clk);
      latency++;
      if (bus3.out_valid === 1'b1) seen = 1'b1;
    end
    checkOutput("narrow out_valid seen", seen, 1);
    gotRes = bus3.res;
  endtask

  initial begin
    logic [8:0] gotRes;
    logic       gotOvf;
    logic [3:0] gotRes3;
    int         busyCycles;
    int         latency;
    int         validCount;
    string      tag;

    rstN          = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.a        = '0;
    bus8.b        = '0;
    bus8.sub      = 1'b0;
    bus8.out_ready = 1'b1;
    bus3.in_valid = 1'b0;
    bus3.a        = '0;
    bus3.b        = '0;
    bus3.sub      = 1'b0;
    bus3.out_ready = 1'b1;

    // Outputs while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", bus8.in_ready, 0);
    checkOutput("reset out_valid", bus8.out_valid, 0);
    checkOutput("reset busy", bus8.busy, 0);
    checkOutput("reset res", bus8.res, 0);
    checkOutput("reset ovf", bus8.ovf, 0);
    rstN = 1'b1;
    #1;
    checkOutput("release in_ready", bus8.in_ready, 1);
    checkOutput("release in_ready narrow", bus3.in_ready, 1);
    @(negedge clk);

    // Arithmetic table with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      bus8.out_ready = 1'b1;
      applyStimulus(vecA[i], vecB[i], vecSub[i], gotRes, gotOvf, busyCycles, latency);
      tag = $sformatf("case%0d", i);
      checkOutput({tag, " res"}, gotRes, vecRes[i]);
      checkOutput({tag, " ovf"}, gotOvf, vecOvf[i] & OVF_ON);
      checkOutput({tag, " busy cycles"}, busyCycles, 4);
      checkOutput({tag, " latency"}, latency, 5);
      @(negedge clk);
      checkOutput({tag, " in_ready after"}, bus8.in_ready, 1);
      checkOutput({tag, " out_valid after"}, bus8.out_valid, 0);
      checkOutput({tag, " ovf cleared"}, bus8.ovf, 0);
    end

    // Result held in DONE while the consumer stalls; new operands ignored.
    bus8.out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, gotRes, gotOvf, busyCycles, latency);
    checkOutput("hold first res", gotRes, 9'h046);
    for (int i = 0; i < 10; i++) begin
      bus8.in_valid = (i % 2 == 0);
      bus8.a        = 8'($urandom);
      bus8.b        = 8'($urandom);
      bus8.sub      = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput($sformatf("hold%0d out_valid", i), bus8.out_valid, 1);
      checkOutput($sformatf("hold%0d res", i), bus8.res, 9'h046);
      checkOutput($sformatf("hold%0d in_ready", i), bus8.in_ready, 0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold release in_ready", bus8.in_ready, 1);
    checkOutput("hold release out_valid", bus8.out_valid, 0);
    @(negedge clk);
    checkOutput("hold no stray run", bus8.busy, 0);

    // Reset asserted in the second RUN cycle.
    bus8.in_valid = 1'b1;
    bus8.a        = 8'd200;
    bus8.b        = 8'd100;
    bus8.sub      = 1'b0;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort first run cycle busy", bus8.busy, 1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort in_ready", bus8.in_ready, 0);
    checkOutput("abort out_valid", bus8.out_valid, 0);
    checkOutput("abort busy", bus8.busy, 0);
    checkOutput("abort res", bus8.res, 0);
    checkOutput("abort ovf", bus8.ovf, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("abort release in_ready", bus8.in_ready, 1);
    validCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.out_valid === 1'b1) validCount++;
    end
    checkOutput("abort no out_valid", validCount, 0);
    applyStimulus(8'd1, 8'd1, 1'b0, gotRes, gotOvf, busyCycles, latency);
    checkOutput("after abort res", gotRes, 9'h002);
    @(negedge clk);

    // Narrow instance: every 3-bit operand pair, one bit per clock.
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        applyStimulusNarrow(3'(x), 3'(y), gotRes3, latency);
        checkOutput($sformatf("narrow %0d+%0d res", x, y), gotRes3, x + y);
        checkOutput($sformatf("narrow %0d+%0d latency", x, y), latency, 4);
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
